leds_jogadores: RTL

//  Output-side counterpart of the player-button encoder: decodes player indices back onto one LED per player.

---
 rtl/poli_lobinho_pkg.sv | 15 +
 rtl/divisor_pisca.sv | 36 +++
 rtl/leds_jogadores.sv | 120 ++++++++++++
 3 files changed

// File: rtl/poli_lobinho_pkg.sv
// Shared constants and FSM state encoding for the player LED/button logic.
// Pure declarations: no latency, no flow control.
package poli_lobinho_pkg;

    localparam int         N_JOGADORES    = 5;
    localparam logic [2:0] JOGADOR_NENHUM = 3'd7;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        ACESO   = 2'd1,
        APAGADO = 2'd2,
        FIM     = 2'd3
    } estado_t;

endpackage

// File: rtl/divisor_pisca.sv
// Free-running tick divider: one-cycle tick every DIV_BLINK cycles, held at 0 while clr_i is high.
// Tick is combinational from the count register; no backpressure.
module divisor_pisca #(
    parameter int DIV_BLINK = 25_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int W = (DIV_BLINK > 1) ? $clog2(DIV_BLINK) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         wrap;

    assign wrap   = (cnt_q == W'(DIV_BLINK - 1));
    assign tick_o = wrap && !clr_i;

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (clr_i || wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/leds_jogadores.sv
// Player LED driver: idle shows current living player, on anunciar flashes the eliminated player(s).
// Outputs are registered one cycle behind the state; anunciar while busy is dropped. LEDS_JOGADORES_ATIVO_BAIXO_EN inverts leds.
module leds_jogadores
    import poli_lobinho_pkg::*;
#(
    parameter int N_JOG     = N_JOGADORES,
    parameter int DIV_BLINK = 25_000_000,
    parameter int N_PISCA   = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mostra,
    input  logic [2:0]       jogador_atual,
    input  logic [N_JOG-1:0] mortes,
    input  logic             anunciar,
    input  logic [2:0]       alvo,
    output logic [N_JOG-1:0] leds,
    output logic             ocupado,
    output logic             fim,
    output logic [1:0]       db_estado
);

    localparam int PW = $clog2(N_PISCA + 1);

    function automatic logic [N_JOG-1:0] onehot(input logic [2:0] idx);
        onehot = '0;
        for (int i = 0; i < N_JOG; i++) begin
            if (int'(idx) == i) onehot[i] = 1'b1;
        end
    endfunction

    estado_t          estado_q, estado_d;
    logic [2:0]       alvo_q, alvo_d;
    logic [N_JOG-1:0] mortes_q, mortes_d;
    logic [PW-1:0]    pisca_q, pisca_d;
    logic [N_JOG-1:0] leds_q, leds_d;
    logic             ocupado_q, ocupado_d;
    logic             fim_q, fim_d;
    logic             tick;
    logic [N_JOG-1:0] padrao;

    divisor_pisca #(
        .DIV_BLINK(DIV_BLINK)
    ) u_divisor (
        .clock (clock),
        .reset (reset),
        .clr_i (estado_q == OCIOSO),
        .tick_o(tick)
    );

    // Out-of-range target means nobody died: every living player flashes.
    assign padrao = (int'(alvo_q) < N_JOG) ? onehot(alvo_q) : ~mortes_q;

    always_comb begin
        estado_d  = estado_q;
        alvo_d    = alvo_q;
        mortes_d  = mortes_q;
        pisca_d   = pisca_q;
        leds_d    = '0;
        ocupado_d = (estado_q != OCIOSO);
        fim_d     = (estado_q == FIM);
        case (estado_q)
            OCIOSO: begin
                if (mostra && int'(jogador_atual) < N_JOG) begin
                    leds_d = onehot(jogador_atual) & ~mortes;
                end
                if (anunciar) begin
                    estado_d = ACESO;
                    alvo_d   = alvo;
                    mortes_d = mortes;
                    pisca_d  = '0;
                end
            end
            ACESO: begin
                leds_d = padrao;
                if (tick) estado_d = APAGADO;
            end
            APAGADO: begin
                if (tick) begin
                    pisca_d  = pisca_q + PW'(1);
                    estado_d = (pisca_q == PW'(N_PISCA - 1)) ? FIM : ACESO;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            alvo_q    <= '0;
            mortes_q  <= '0;
            pisca_q   <= '0;
            leds_q    <= '0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            alvo_q    <= alvo_d;
            mortes_q  <= mortes_d;
            pisca_q   <= pisca_d;
            leds_q    <= leds_d;
            ocupado_q <= ocupado_d;
            fim_q     <= fim_d;
        end
    end

`ifdef LEDS_JOGADORES_ATIVO_BAIXO_EN
    assign leds = ~leds_q;
`else
    assign leds = leds_q;
`endif
    assign ocupado   = ocupado_q;
    assign fim       = fim_q;
    assign db_estado = estado_q;

endmodule
